// File: rtl/pll_rst_pkg.sv
// Shared state encoding and widths for the PLL reset and lock supervisor.
package pll_rst_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned RELOCK_W = 8;

    typedef enum logic [STATE_W-1:0] {
        StRstPll   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } state_e;

endpackage

// File: rtl/pll_rst_ctrl_if.sv
// Signal bundle between the reset supervisor, the PLL it drives and the logic it gates.
interface pll_rst_ctrl_if;
    import pll_rst_pkg::*;

    logic                pll_lock;
    logic                pll_rst;
    logic                sys_rst_n;
    logic                lock_ok;
    logic                pll_fail;
    logic [RELOCK_W-1:0] relock_cnt;
    logic [STATE_W-1:0]  state_o;

    modport master (
        input  pll_lock,
        output pll_rst,
        output sys_rst_n,
        output lock_ok,
        output pll_fail,
        output relock_cnt,
        output state_o
    );

    modport slave (
        output pll_lock,
        input  pll_rst,
        input  sys_rst_n,
        input  lock_ok,
        input  pll_fail,
        input  relock_cnt,
        input  state_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset to zero.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset and lock supervisor: pulses the PLL reset, waits for a stable lock, then
// releases the system reset; retries on lock timeout and parks in a sticky fail state.
module pll_rst_ctrl
    import pll_rst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned MAX_RETRY      = 4,
    parameter int unsigned CNT_W          = 16
) (
    input logic            clk,
    input logic            rst_n,
    pll_rst_ctrl_if.master bus
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_rst_n_q, sys_rst_n_d;
    logic                lock_ok_q, lock_ok_d;
    logic                pll_fail_q, pll_fail_d;
    logic                lock_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRstPll;
            cnt_q       <= '0;
            retry_q     <= '0;
            relock_q    <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            pll_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            relock_q    <= relock_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            lock_ok_q   <= lock_ok_d;
            pll_fail_q  <= pll_fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        cnt_d    = cnt_q + 1'b1;
        unique case (state_q)
            StRstPll: begin
                if (cnt_q == RST_LAST) state_d = StWaitLock;
            end
            StWaitLock: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lock_s) begin
                    state_d = StStable;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 1'b1;
                    state_d = (retry_d == RETRY_MAX) ? StFail : StRstPll;
                end
            end
            StStable: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q;
                if (!lock_s) begin
                    state_d = StRstPll;
                    if (relock_q != '1) relock_d = relock_q + 1'b1;
                end
            end
            StFail: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = StRstPll;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
        if (state_d == StRun) retry_d = '0;
    end

    always_comb begin
        pll_rst_d   = 1'b0;
        sys_rst_n_d = 1'b0;
        lock_ok_d   = 1'b0;
        pll_fail_d  = 1'b0;
        unique case (state_d)
            StRstPll: pll_rst_d = 1'b1;
            StRun: begin
                sys_rst_n_d = 1'b1;
                lock_ok_d   = 1'b1;
            end
            StFail:   pll_fail_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.pll_rst    = pll_rst_q;
    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.lock_ok    = lock_ok_q;
    assign bus.pll_fail   = pll_fail_q;
    assign bus.relock_cnt = relock_q;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scoreboard bench for pll_rst_ctrl with reduced timing parameters.
module tb_pll_rst_ctrl;
    import pll_rst_pkg::*;

    localparam int unsigned PRC = 4;
    localparam int unsigned LT  = 20;
    localparam int unsigned LS  = 8;
    localparam int unsigned MR  = 3;

    localparam int SEL_PLL_RST   = 0;
    localparam int SEL_SYS_RST_N = 1;
    localparam int SEL_PLL_FAIL  = 2;
    localparam int SEL_STABLE    = 3;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    pll_rst_ctrl_if bus ();

    pll_rst_ctrl #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LT),
        .LOCK_STABLE    (LS),
        .MAX_RETRY      (MR),
        .CNT_W          (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_exp(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb_q.push_back(e);
    endfunction

    function automatic logic [31:0] exp_status(input logic pr, input logic sr, input logic lo,
                                               input logic pf, input logic [7:0] rc,
                                               input logic [2:0] st);
        return {17'd0, pr, sr, lo, pf, rc, st};
    endfunction

    function automatic logic [31:0] status();
        return {17'd0, bus.pll_rst, bus.sys_rst_n, bus.lock_ok, bus.pll_fail, bus.relock_cnt,
                bus.state_o};
    endfunction

    function automatic logic pick(input int sel);
        case (sel)
            SEL_PLL_RST:   return bus.pll_rst;
            SEL_SYS_RST_N: return bus.sys_rst_n;
            SEL_PLL_FAIL:  return bus.pll_fail;
            default:       return logic'(bus.state_o == StStable);
        endcase
    endfunction

    // Cycles until the selected signal shows val; -1 when the budget runs out.
    task automatic wait_sig(input int sel, input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (pick(sel) === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic apply_reset(input logic lock);
        rst_n        = 1'b0;
        bus.pll_lock = lock;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        rst_n        = 1'b0;
        bus.pll_lock = 1'b0;
        push_exp("reset_values", exp_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, StRstPll));
        repeat (2) tick();
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        bus.pll_lock = 1'b1;
        push_exp("reset_held_with_lock", exp_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, StRstPll));
        repeat (5) tick();
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
    endtask

    task automatic test_nominal();
        exp_t e;
        logic [31:0] obs;
        int n;
        apply_reset(1'b0);
        push_exp("nominal_pll_rst_width", 32'(PRC));
        wait_sig(SEL_PLL_RST, 1'b0, 50, n);
        e = sb_q.pop_front(); obs = 32'(n); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        push_exp("nominal_waiting", exp_status(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, StWaitLock));
        repeat (5) tick();
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        bus.pll_lock = 1'b1;
        // Count from the first edge that samples the new lock level.
        push_exp("nominal_release_delay", 32'(2 + LS));
        tick();
        wait_sig(SEL_SYS_RST_N, 1'b1, 50, n);
        e = sb_q.pop_front(); obs = 32'(n); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        push_exp("nominal_run", exp_status(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, StRun));
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        logic [31:0] obs;
        int n;
        apply_reset(1'b0);
        wait_sig(SEL_PLL_RST, 1'b0, 50, n);
        bus.pll_lock = 1'b1;
        push_exp("glitch_enter_stable", 32'd3);
        wait_sig(SEL_STABLE, 1'b1, 20, n);
        e = sb_q.pop_front(); obs = 32'(n); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        repeat (4) tick();
        bus.pll_lock = 1'b0;
        push_exp("glitch_back_to_wait", exp_status(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, StWaitLock));
        repeat (3) tick();
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        bus.pll_lock = 1'b1;
        push_exp("glitch_release_delay", 32'(2 + LS));
        tick();
        wait_sig(SEL_SYS_RST_N, 1'b1, 50, n);
        e = sb_q.pop_front(); obs = 32'(n); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic [31:0] obs;
        logic prev;
        bit done;
        int bad;
        apply_reset(1'b0);
        for (int k = 1; k < int'(MR); k++) begin
            push_exp($sformatf("timeout_rise_%0d", k), 32'(k * int'(PRC + LT)));
        end
        push_exp("timeout_fail_cycle", 32'(MR * (PRC + LT)));
        prev = bus.pll_rst;
        done = 1'b0;
        for (int t = 1; t <= 200 && !done; t++) begin
            tick();
            if ((bus.pll_rst && !prev) || bus.pll_fail) begin
                done = bus.pll_fail;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL timeout_extra_event: observed cycle %0d, expected none", t);
                end else begin
                    e = sb_q.pop_front(); obs = 32'(t);
                    if (obs !== e.val) begin
                        n_fail++;
                        $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
                    end
                end
            end
            prev = bus.pll_rst;
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); n_checks++; n_fail++;
            $display("FAIL %s: observed none, expected %0h", e.name, e.val);
        end
        push_exp("timeout_fail_state", exp_status(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, StFail));
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        bus.pll_lock = 1'b1;
        bad = 0;
        push_exp("timeout_fail_sticky", 32'd0);
        repeat (40) begin
            tick();
            if (status() !== exp_status(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, StFail)) bad++;
        end
        e = sb_q.pop_front(); obs = 32'(bad); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
    endtask

    task automatic test_boundary();
        exp_t e;
        logic [31:0] obs;
        logic prev;
        int rises;
        apply_reset(1'b0);
        repeat (21) tick();
        bus.pll_lock = 1'b1;
        push_exp("boundary_still_wait", exp_status(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, StWaitLock));
        push_exp("boundary_lock_wins", exp_status(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, StStable));
        repeat (2) tick();
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        tick();
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        // A full retry budget must still be available after the tie.
        bus.pll_lock = 1'b0;
        push_exp("boundary_retries_left", 32'(MR - 1));
        prev = bus.pll_rst;
        rises = 0;
        for (int t = 0; t < 200 && !bus.pll_fail; t++) begin
            tick();
            if (bus.pll_rst && !prev) rises++;
            prev = bus.pll_rst;
        end
        e = sb_q.pop_front(); obs = bus.pll_fail ? 32'(rises) : 32'hffff_ffff; n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
    endtask

    task automatic test_relock();
        exp_t e;
        logic [31:0] obs;
        int n;
        apply_reset(1'b1);
        push_exp("relock_first_run", 32'(PRC + 1 + LS));
        wait_sig(SEL_SYS_RST_N, 1'b1, 60, n);
        e = sb_q.pop_front(); obs = 32'(n); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        bus.pll_lock = 1'b0;
        push_exp("relock_drop_delay", 32'd2);
        tick();
        wait_sig(SEL_SYS_RST_N, 1'b0, 20, n);
        e = sb_q.pop_front(); obs = 32'(n); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        push_exp("relock_drop_state", exp_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, StRstPll));
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        push_exp("relock_pll_rst_width", 32'(PRC));
        wait_sig(SEL_PLL_RST, 1'b0, 20, n);
        e = sb_q.pop_front(); obs = 32'(n); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        bus.pll_lock = 1'b1;
        push_exp("relock_rerun", exp_status(1'b0, 1'b1, 1'b1, 1'b0, 8'd1, StRun));
        tick();
        wait_sig(SEL_SYS_RST_N, 1'b1, 40, n);
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        for (int i = 2; i <= 300; i++) begin
            bus.pll_lock = 1'b0;
            push_exp($sformatf("relock_cnt_%0d", i), 32'((i > 255) ? 255 : i));
            wait_sig(SEL_SYS_RST_N, 1'b0, 10, n);
            e = sb_q.pop_front(); obs = (n < 0) ? 32'hffff_ffff : 32'(bus.relock_cnt);
            n_checks++;
            if (obs !== e.val) begin
                n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
                break;
            end
            bus.pll_lock = 1'b1;
            push_exp($sformatf("relock_rerun_%0d", i), 32'(PRC + 1 + LS));
            wait_sig(SEL_SYS_RST_N, 1'b1, 40, n);
            e = sb_q.pop_front(); obs = 32'(n); n_checks++;
            if (obs !== e.val) begin
                n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
                break;
            end
        end
        sb_q.delete();
        push_exp("relock_saturated", exp_status(1'b0, 1'b1, 1'b1, 1'b0, 8'd255, StRun));
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [31:0] obs;
        int n;
        // Entered from RUN with relock_cnt saturated; reset lands between clock edges.
        #5;
        rst_n = 1'b0;
        push_exp("async_run_reset", exp_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, StRstPll));
        #1;
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        #2;
        rst_n = 1'b1;
        push_exp("async_run_restart", 32'(PRC));
        wait_sig(SEL_PLL_RST, 1'b0, 50, n);
        e = sb_q.pop_front(); obs = 32'(n); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        apply_reset(1'b0);
        push_exp("async_reach_fail", 32'(MR * (PRC + LT)));
        wait_sig(SEL_PLL_FAIL, 1'b1, 200, n);
        e = sb_q.pop_front(); obs = 32'(n); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        #5;
        rst_n = 1'b0;
        push_exp("async_fail_reset", exp_status(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, StRstPll));
        #1;
        e = sb_q.pop_front(); obs = status(); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
        #2;
        rst_n = 1'b1;
        push_exp("async_fail_restart", 32'(PRC));
        wait_sig(SEL_PLL_RST, 1'b0, 50, n);
        e = sb_q.pop_front(); obs = 32'(n); n_checks++;
        if (obs !== e.val) begin
            n_fail++; $display("FAIL %s: observed %0h, expected %0h", e.name, obs, e.val);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.pll_lock = 1'b0;
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_boundary();
        test_relock();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
